output_tile_scheduler: RTL and testbench
========================================

// Module: output_tile_scheduler
// PURPOSE
//  Walks the output matrix as a grid of SYS_ARR_ROWS x SYS_ARR_COLS tiles, row-major with the column index innermost.
//  For each tile it waits for the accumulator tile to be ready, then programs and starts master_output_ctrl.
//  It waits for that controller to finish, acknowledges the tile and moves on. Edge tiles are partial.
//  Sits between the host command interface and master_output_ctrl.
// PARAMETERS
//  MAX_OUT_ROWS  128  max output-matrix rows
//  MAX_OUT_COLS  128  max output-matrix cols
//  SYS_ARR_ROWS  16   tile height (systolic rows)
//  SYS_ARR_COLS  16   tile width (systolic cols)
//  ADDR_WIDTH    8    output-buffer address width
//  derived: NM=MAX_OUT_ROWS/SYS_ARR_ROWS, NN=MAX_OUT_COLS/SYS_ARR_COLS, RW=$clog2(MAX_OUT_ROWS)+1, CW=$clog2(MAX_OUT_COLS)+1
// PORTS
//  clk               in   1               clock; all state changes on posedge
//  reset             in   1               synchronous, active-low reset
//  cmd_valid         in   1               host command request
//  cmd_ready         out  1               high only in IDLE; command accepted when cmd_valid&cmd_ready
//  cfg_rows          in   RW              output rows, 0..MAX_OUT_ROWS
//  cfg_cols          in   CW              output cols, 0..MAX_OUT_COLS
//  cfg_base_addr     in   ADDR_WIDTH      output-buffer base address
//  cfg_activate      in   1               apply ReLU on write-out
//  cfg_clear_after   in   1               clear accumulators after each tile
//  tile_valid        in   1               accumulator holds the current tile
//  tile_ack          out  1               1-cycle pulse: current tile drained
//  oc_start          out  1               1-cycle start pulse to master_output_ctrl
//  oc_submatrix_row  out  $clog2(NM)      tile row index
//  oc_submatrix_col  out  $clog2(NN)      tile col index
//  oc_read_rows_num  out  $clog2(SYS_ARR_ROWS)  rows in tile minus 1
//  oc_read_cols_num  out  $clog2(SYS_ARR_COLS)  cols in tile minus 1
//  oc_wr_base_addr   out  ADDR_WIDTH      tile base address
//  oc_activate       out  1               latched cfg_activate
//  oc_clear_after    out  1               latched cfg_clear_after
//  oc_done           in   1               master_output_ctrl idle (high = idle)
//  busy              out  1               high in any state except IDLE
//  done              out  1               1-cycle pulse: whole matrix written
//  tiles_done        out  $clog2(NM*NN)+1 tiles completed in current command
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; all outputs 0 except cmd_ready=1; counters and config regs cleared.
//  Reset mid-command aborts immediately with no done pulse. master_output_ctrl is reset separately.
//  On accept, latch the config. Values above MAX_* are clamped to MAX_*.
//  Compute tile counts: TR=ceil(rows/SYS_ARR_ROWS), TC=ceil(cols/SYS_ARR_COLS). Clear tile_r, tile_c and tiles_done.
//  FSM:
//   IDLE  -> CHECK on accept.
//   CHECK -> FIN if rows==0 or cols==0; otherwise -> WAIT_T.
//   WAIT_T: hold until tile_valid==1 and oc_done==1, then -> ISSUE.
//   ISSUE: oc_start=1 for exactly 1 cycle, with oc_* fields stable; -> ARM.
//   ARM: one cycle, ignoring oc_done (it drops one cycle after start); -> DRAIN.
//   DRAIN: wait for oc_done==1; then tile_ack=1 for 1 cycle, tiles_done++; -> NEXT.
//   NEXT: if tile_c==TC-1 then tile_c=0 and tile_r++, else tile_c++.
//         After the last tile (tile_r==TR-1, tile_c==TC-1) -> FIN; otherwise -> WAIT_T.
//   FIN: done=1 for 1 cycle; -> IDLE.
//  oc_* fields are registered and stay constant from WAIT_T through DRAIN for a given tile.
//  oc_read_rows_num = min(SYS_ARR_ROWS, rows - tile_r*SYS_ARR_ROWS) - 1; cols computed the same way.
//  oc_wr_base_addr = cfg_base_addr + (tile_r*NN + tile_c)*SYS_ARR_ROWS, modulo 2^ADDR_WIDTH (wrap, no error).
//  cmd_valid outside IDLE is ignored (not queued). tile_valid is ignored outside WAIT_T.
//  tiles_done holds its final value until the next accept or reset.
// TESTING
//  1) rows=32, cols=32, base=0, oc_done modelled as low for 17 cycles after start.
//     -> 4 oc_start; (r,c) order (0,0),(0,1),(1,0),(1,1); addrs 0,16,128,144; rows/cols_num=15; done once; tiles_done=4.
//  2) rows=20, cols=5.
//     -> tiles (0,0) with rows_num=15, cols_num=4, then (1,0) with rows_num=3, cols_num=4; done after 2 acks.
//  3) rows=0, cols=16.
//     -> no oc_start; done pulses within 3 cycles of accept; tiles_done=0.
//  4) tile_valid held low for 50 cycles, or oc_done low at WAIT_T.
//     -> no oc_start until both are high; cmd_valid asserted while busy leaves cmd_ready=0 and the command is not accepted.
//  5) reset=0 for one cycle during DRAIN of tile 2.
//     -> next cycle IDLE, cmd_ready=1, busy=0, no done or tile_ack; a fresh command restarts at (0,0).
//  6) base=240, rows=128, cols=16.
//     -> addresses wrap: tile 1 at 240+128 mod 256 = 112; all 8 tiles issued with rows_num=15.

Source files
------------

// File: rtl/output_tile_scheduler.sv
// Tile sequencer for the output write-out path: walks the output matrix tile by tile
// (row-major, column innermost) and hands each tile to master_output_ctrl.
module output_tile_scheduler #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    localparam int NM  = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NN  = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int RW  = $clog2(MAX_OUT_ROWS) + 1,
    localparam int CW  = $clog2(MAX_OUT_COLS) + 1,
    localparam int TRW = $clog2(NM) + 1,
    localparam int TCW = $clog2(NN) + 1,
    localparam int RNW = $clog2(SYS_ARR_ROWS),
    localparam int CNW = $clog2(SYS_ARR_COLS),
    localparam int TDW = $clog2(NM * NN) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RW-1:0]         cfg_rows,
    input  logic [CW-1:0]         cfg_cols,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic                  cfg_activate,
    input  logic                  cfg_clear_after,
    input  logic                  tile_valid,
    output logic                  tile_ack,
    output logic                  oc_start,
    output logic [$clog2(NM)-1:0] oc_submatrix_row,
    output logic [$clog2(NN)-1:0] oc_submatrix_col,
    output logic [RNW-1:0]        oc_read_rows_num,
    output logic [CNW-1:0]        oc_read_cols_num,
    output logic [ADDR_WIDTH-1:0] oc_wr_base_addr,
    output logic                  oc_activate,
    output logic                  oc_clear_after,
    input  logic                  oc_done,
    output logic                  busy,
    output logic                  done,
    output logic [TDW-1:0]        tiles_done,
    output logic [2:0]            dbg_state
);

    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WAIT_T = 3'd2,
        S_ISSUE  = 3'd3,
        S_ARM    = 3'd4,
        S_DRAIN  = 3'd5,
        S_NEXT   = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RW-1:0]           r_rows;
    logic [CW-1:0]           r_cols;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic                    r_act;
    logic                    r_clr;
    logic [$clog2(NM)-1:0]   r_tile_r;
    logic [$clog2(NN)-1:0]   r_tile_c;
    logic [TDW-1:0]          r_tiles_done;
    logic [RNW-1:0]          r_oc_rows_num;
    logic [CNW-1:0]          r_oc_cols_num;
    logic [ADDR_WIDTH-1:0]   r_oc_addr;
    logic [$clog2(NM)-1:0]   r_oc_row;
    logic [$clog2(NN)-1:0]   r_oc_col;

    logic                    w_accept;
    logic                    w_empty;
    logic [TRW-1:0]          w_tr;
    logic [TCW-1:0]          w_tc;
    logic                    w_last_r;
    logic                    w_last_c;
    logic                    w_last;
    logic                    w_load_tile;
    logic [$clog2(NM)-1:0]   w_sel_r;
    logic [$clog2(NN)-1:0]   w_sel_c;
    logic [RW-1:0]           w_row_rem;
    logic [CW-1:0]           w_col_rem;
    logic [RNW-1:0]          w_rows_num;
    logic [CNW-1:0]          w_cols_num;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_empty  = (r_rows == '0) || (r_cols == '0);
    assign w_tr     = TRW'((int'(r_rows) + SYS_ARR_ROWS - 1) / SYS_ARR_ROWS);
    assign w_tc     = TCW'((int'(r_cols) + SYS_ARR_COLS - 1) / SYS_ARR_COLS);
    assign w_last_r = (TRW'(r_tile_r) == w_tr - TRW'(1));
    assign w_last_c = (TCW'(r_tile_c) == w_tc - TCW'(1));
    assign w_last   = w_last_r && w_last_c;
    assign w_load_tile = ((r_state == S_CHECK) && !w_empty) || ((r_state == S_NEXT) && !w_last);

    // Fields for the tile about to be worked on, so they are already stable on entry to WAIT_T.
    always_comb begin
        w_sel_r = r_tile_r;
        w_sel_c = r_tile_c;
        if (r_state == S_CHECK) begin
            w_sel_r = '0;
            w_sel_c = '0;
        end else if (w_last_c) begin
            w_sel_c = '0;
            w_sel_r = r_tile_r + 1'b1;
        end else begin
            w_sel_c = r_tile_c + 1'b1;
        end
    end

    assign w_row_rem  = r_rows - RW'(int'(w_sel_r) * SYS_ARR_ROWS);
    assign w_col_rem  = r_cols - CW'(int'(w_sel_c) * SYS_ARR_COLS);
    assign w_rows_num = (w_row_rem >= RW'(SYS_ARR_ROWS)) ? RNW'(SYS_ARR_ROWS - 1)
                                                         : RNW'(w_row_rem - RW'(1));
    assign w_cols_num = (w_col_rem >= CW'(SYS_ARR_COLS)) ? CNW'(SYS_ARR_COLS - 1)
                                                         : CNW'(w_col_rem - CW'(1));
    // Address wraps modulo 2^ADDR_WIDTH by truncation.
    assign w_addr = r_base + ADDR_WIDTH'((int'(w_sel_r) * NN + int'(w_sel_c)) * SYS_ARR_ROWS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = w_empty ? S_FIN : S_WAIT_T;
            S_WAIT_T: if (tile_valid && oc_done) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_ARM;
            S_ARM:    w_state_nxt = S_DRAIN;
            S_DRAIN:  if (oc_done) w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = w_last ? S_FIN : S_WAIT_T;
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rows        <= '0;
            r_cols        <= '0;
            r_base        <= '0;
            r_act         <= 1'b0;
            r_clr         <= 1'b0;
            r_tile_r      <= '0;
            r_tile_c      <= '0;
            r_tiles_done  <= '0;
            r_oc_rows_num <= '0;
            r_oc_cols_num <= '0;
            r_oc_addr     <= '0;
            r_oc_row      <= '0;
            r_oc_col      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rows       <= (cfg_rows > RW'(MAX_OUT_ROWS)) ? RW'(MAX_OUT_ROWS) : cfg_rows;
                r_cols       <= (cfg_cols > CW'(MAX_OUT_COLS)) ? CW'(MAX_OUT_COLS) : cfg_cols;
                r_base       <= cfg_base_addr;
                r_act        <= cfg_activate;
                r_clr        <= cfg_clear_after;
                r_tile_r     <= '0;
                r_tile_c     <= '0;
                r_tiles_done <= '0;
            end
            if (w_load_tile) begin
                r_tile_r      <= w_sel_r;
                r_tile_c      <= w_sel_c;
                r_oc_row      <= w_sel_r;
                r_oc_col      <= w_sel_c;
                r_oc_rows_num <= w_rows_num;
                r_oc_cols_num <= w_cols_num;
                r_oc_addr     <= w_addr;
            end
            if ((r_state == S_DRAIN) && oc_done) begin
                r_tiles_done <= r_tiles_done + 1'b1;
            end
        end
    end

    assign cmd_ready        = (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign oc_start         = (r_state == S_ISSUE);
    assign tile_ack         = (r_state == S_DRAIN) && oc_done;
    assign done             = (r_state == S_FIN);
    assign tiles_done       = r_tiles_done;
    assign oc_submatrix_row = r_oc_row;
    assign oc_submatrix_col = r_oc_col;
    assign oc_read_rows_num = r_oc_rows_num;
    assign oc_read_cols_num = r_oc_cols_num;
    assign oc_wr_base_addr  = r_oc_addr;
    assign oc_activate      = r_act;
    assign oc_clear_after   = r_clr;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_output_tile_scheduler.sv
// Directed bench for output_tile_scheduler: a master_output_ctrl responder model and a
// scoreboard of expected tile descriptors checked at every oc_start.
module tb_output_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cfg_rows = '0;
  logic [7:0] cfg_cols = '0;
  logic [7:0] cfg_base_addr = '0;
  logic       cfg_activate = 1'b0;
  logic       cfg_clear_after = 1'b0;
  logic       tile_valid = 1'b1;
  logic       tile_ack;
  logic       oc_start;
  logic [2:0] oc_submatrix_row;
  logic [2:0] oc_submatrix_col;
  logic [3:0] oc_read_rows_num;
  logic [3:0] oc_read_cols_num;
  logic [7:0] oc_wr_base_addr;
  logic       oc_activate;
  logic       oc_clear_after;
  logic       oc_done;
  logic       busy;
  logic       done;
  logic [6:0] tiles_done;
  logic [2:0] dbg_state;

  output_tile_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base_addr(cfg_base_addr),
    .cfg_activate(cfg_activate), .cfg_clear_after(cfg_clear_after),
    .tile_valid(tile_valid), .tile_ack(tile_ack), .oc_start(oc_start),
    .oc_submatrix_row(oc_submatrix_row), .oc_submatrix_col(oc_submatrix_col),
    .oc_read_rows_num(oc_read_rows_num), .oc_read_cols_num(oc_read_cols_num),
    .oc_wr_base_addr(oc_wr_base_addr), .oc_activate(oc_activate),
    .oc_clear_after(oc_clear_after), .oc_done(oc_done), .busy(busy), .done(done),
    .tiles_done(tiles_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // master_output_ctrl responder: idle drops after a start and returns 17 cycles later
  logic oc_idle = 1'b1;
  logic oc_block = 1'b0;
  int   oc_cnt = 0;
  assign oc_done = oc_idle && !oc_block;

  always @(posedge clk) begin
    if (oc_start) begin
      oc_idle <= 1'b0;
      oc_cnt  <= 17;
    end else if (oc_cnt > 0) begin
      oc_cnt <= oc_cnt - 1;
      if (oc_cnt == 1) oc_idle <= 1'b1;
    end
  end

  // scoreboard
  logic [21:0] exp_q[$];
  logic        exp_act = 1'b0;
  logic        exp_clr = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int start_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] tdesc(input int r, input int c, input int rn, input int cn, input int a);
    return {3'(r), 3'(c), 4'(rn), 4'(cn), 8'(a)};
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (tile_ack) ack_cnt++;
    if (oc_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check_val("start_unexpected", 32'd1, 32'd0);
      end else begin
        check_val("tile_desc",
                  {10'd0, oc_submatrix_row, oc_submatrix_col, oc_read_rows_num,
                   oc_read_cols_num, oc_wr_base_addr},
                  {10'd0, exp_q.pop_front()});
        check_val("oc_activate", {31'd0, oc_activate}, {31'd0, exp_act});
        check_val("oc_clear_after", {31'd0, oc_clear_after}, {31'd0, exp_clr});
      end
    end
  end

  // driver tasks
  task automatic send_cmd(input int rows, input int cols, input int base, input logic act, input logic clr);
    @(negedge clk);
    check_val("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cfg_rows = 8'(rows);
    cfg_cols = 8'(cols);
    cfg_base_addr = 8'(base);
    cfg_activate = act;
    cfg_clear_after = clr;
    exp_act = act;
    exp_clr = clr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    int start;
    start = done_cnt;
    lat = 0;
    while (done_cnt == start && lat < max_cyc) begin
      @(posedge clk);
      lat++;
    end
    check_val("done_seen", {31'd0, done_cnt != start}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  int lat;
  int s0;
  int d0;
  int a0;
  int guard;

  initial begin
    reset = 1'b0;
    idle_cycles(3);
    #1 reset = 1'b1;

    // reset state
    @(negedge clk);
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_oc_start", {31'd0, oc_start}, 32'd0);
    check_val("rst_tile_ack", {31'd0, tile_ack}, 32'd0);
    check_val("rst_tiles_done", {25'd0, tiles_done}, 32'd0);
    check_val("rst_addr", {24'd0, oc_wr_base_addr}, 32'd0);
    check_val("rst_act", {31'd0, oc_activate}, 32'd0);

    // 1) 32x32 from base 0: four full tiles
    exp_q.push_back(tdesc(0, 0, 15, 15, 0));
    exp_q.push_back(tdesc(0, 1, 15, 15, 16));
    exp_q.push_back(tdesc(1, 0, 15, 15, 128));
    exp_q.push_back(tdesc(1, 1, 15, 15, 144));
    s0 = start_cnt; d0 = done_cnt; a0 = ack_cnt;
    send_cmd(32, 32, 0, 1'b1, 1'b1);
    wait_done(500, lat);
    @(negedge clk);
    check_val("t1_starts", start_cnt - s0, 32'd4);
    check_val("t1_acks", ack_cnt - a0, 32'd4);
    check_val("t1_done_once", done_cnt - d0, 32'd1);
    check_val("t1_tiles_done", {25'd0, tiles_done}, 32'd4);
    check_val("t1_q_empty", exp_q.size(), 32'd0);
    check_val("t1_idle", {31'd0, busy}, 32'd0);

    // 2) 20x5: partial tiles on both edges
    exp_q.push_back(tdesc(0, 0, 15, 4, 0));
    exp_q.push_back(tdesc(1, 0, 3, 4, 128));
    s0 = start_cnt; a0 = ack_cnt;
    send_cmd(20, 5, 0, 1'b0, 1'b0);
    wait_done(500, lat);
    @(negedge clk);
    check_val("t2_starts", start_cnt - s0, 32'd2);
    check_val("t2_acks", ack_cnt - a0, 32'd2);
    check_val("t2_tiles_done", {25'd0, tiles_done}, 32'd2);

    // 3) zero rows: finishes without issuing
    s0 = start_cnt;
    send_cmd(0, 16, 0, 1'b0, 1'b0);
    wait_done(20, lat);
    check_val("t3_done_latency_le3", {31'd0, lat <= 3}, 32'd1);
    @(negedge clk);
    check_val("t3_no_start", start_cnt - s0, 32'd0);
    check_val("t3_tiles_done", {25'd0, tiles_done}, 32'd0);

    // 4) tile_valid low, then oc_done low, gate the start; a busy-time command is ignored
    tile_valid = 1'b0;
    exp_q.push_back(tdesc(0, 0, 15, 15, 5));
    s0 = start_cnt; d0 = done_cnt;
    send_cmd(16, 16, 5, 1'b0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cfg_rows = 8'd64;
    cfg_cols = 8'd64;
    @(negedge clk);
    check_val("t4_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    check_val("t4_busy", {31'd0, busy}, 32'd1);
    idle_cycles(3);
    #1 cmd_valid = 1'b0;
    idle_cycles(45);
    check_val("t4_no_start_tv_low", start_cnt - s0, 32'd0);
    #1;
    oc_block = 1'b1;
    tile_valid = 1'b1;
    idle_cycles(10);
    check_val("t4_no_start_oc_busy", start_cnt - s0, 32'd0);
    #1 oc_block = 1'b0;
    wait_done(500, lat);
    @(negedge clk);
    check_val("t4_starts", start_cnt - s0, 32'd1);
    check_val("t4_done_once", done_cnt - d0, 32'd1);
    check_val("t4_tiles_done", {25'd0, tiles_done}, 32'd1);
    check_val("t4_idle_after", {31'd0, cmd_ready}, 32'd1);

    // 5) reset during DRAIN of the second tile
    exp_q.push_back(tdesc(0, 0, 15, 15, 0));
    exp_q.push_back(tdesc(0, 1, 15, 15, 16));
    s0 = start_cnt;
    send_cmd(32, 32, 0, 1'b0, 1'b0);
    guard = 0;
    while (start_cnt - s0 < 2 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check_val("t5_second_start", start_cnt - s0, 32'd2);
    idle_cycles(2);
    #1;
    check_val("t5_in_drain", {29'd0, dbg_state}, 32'd5);
    reset = 1'b0;
    d0 = done_cnt; a0 = ack_cnt;
    @(posedge clk);
    #1 reset = 1'b1;
    check_val("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("t5_busy", {31'd0, busy}, 32'd0);
    check_val("t5_tiles_done", {25'd0, tiles_done}, 32'd0);
    idle_cycles(30);
    check_val("t5_no_done", done_cnt - d0, 32'd0);
    check_val("t5_no_ack", ack_cnt - a0, 32'd0);
    check_val("t5_q_empty", exp_q.size(), 32'd0);
    exp_q.push_back(tdesc(0, 0, 15, 15, 0));
    send_cmd(16, 16, 0, 1'b0, 1'b0);
    wait_done(500, lat);
    @(negedge clk);
    check_val("t5_restart_tiles", {25'd0, tiles_done}, 32'd1);

    // 6) base 240, 128x16: addresses wrap modulo 256
    for (int r = 0; r < 8; r++) begin
      exp_q.push_back(tdesc(r, 0, 15, 15, (r % 2 == 1) ? 112 : 240));
    end
    s0 = start_cnt;
    send_cmd(128, 16, 240, 1'b1, 1'b0);
    wait_done(1000, lat);
    @(negedge clk);
    check_val("t6_starts", start_cnt - s0, 32'd8);
    check_val("t6_tiles_done", {25'd0, tiles_done}, 32'd8);
    check_val("t6_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
